// File: rtl/plate_entry_pkg.sv
// Shared definitions for the keypad-to-plate front end: key codes, the
// blank display nibble, default sizing and the entry state encoding.
package plate_entry_pkg;

  // Scanner key codes: 0x0..KEY_CHAR_MAX are plate characters.
  localparam logic [3:0] KEY_CHAR_MAX = 4'hD;
  localparam logic [3:0] KEY_BKSP     = 4'hE;
  localparam logic [3:0] KEY_ENTER    = 4'hF;

  // Nibble shown in unfilled positions; the LCD renders it as '_'.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Default sizing used by the top level.
  localparam int N_CHARS_DEF       = 6;
  localparam int TIMEOUT_TICKS_DEF = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // True for codes that enter a character into the plate.
  function automatic logic is_char(input logic [3:0] code);
    return (code <= KEY_CHAR_MAX);
  endfunction

endpackage

// File: rtl/plate_entry_key_edge.sv
// Key front end: turns the scanner's held key_valid level into a single
// registered press event, latches the code with it, and flags a long hold.
module key_edge
  import plate_entry_pkg::*;
#(
  parameter int HOLD_TICKS = TIMEOUT_TICKS_DEF / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] key_code_q,
  output logic       long_hold
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic          key_prev;
  logic [HW-1:0] hold_cnt;

  // Rising-edge detect, code capture on the edge, and a saturating hold
  // counter that fires long_hold once when the hold reaches HOLD_TICKS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev   <= 1'b0;
      key_evt    <= 1'b0;
      key_code_q <= 4'h0;
      long_hold  <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      key_prev  <= key_valid;
      key_evt   <= key_valid & ~key_prev;
      long_hold <= 1'b0;
      if (key_valid && !key_prev) begin
        key_code_q <= key_code;
        hold_cnt   <= HW'(1);
      end else if (key_valid) begin
        if (hold_cnt != HW'(HOLD_TICKS)) begin
          hold_cnt <= hold_cnt + HW'(1);
        end
        if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
          long_hold <= 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/plate_entry.sv
// Keypad-to-plate front end between the keypad scanner and the parking FSM.
// Collects up to N_CHARS nibbles with backspace/clear, shows a live image for
// the LCD, commits a non-zero plate on ENTER and discards idle entries.
module plate_entry
  import plate_entry_pkg::*;
#(
  parameter int N_CHARS       = N_CHARS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic [4*N_CHARS-1:0] plate_disp,
  output logic [4*N_CHARS-1:0] plate_out,
  output logic                 plate_valid,
  output logic [2:0]           char_count,
  output logic                 timeout
);

  localparam int             PW          = 4 * N_CHARS;
  localparam int             IW          = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [2:0]     FULL        = 3'(N_CHARS);
  localparam logic [PW-1:0]  BLANK_PLATE = {N_CHARS{BLANK_CODE}};
  localparam logic [IW-1:0]  IDLE_LAST   = IW'(TIMEOUT_TICKS - 1);
  localparam logic [IW-1:0]  IDLE_SAT    = IW'(TIMEOUT_TICKS);

  state_t        state;
  logic          key_evt;
  logic          long_hold;
  logic [3:0]    key_code_q;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_next;
  logic [PW-1:0] plate_add;
  logic [PW-1:0] plate_del;
  logic          bksp_clear;
  logic          can_commit;

  key_edge #(
    .HOLD_TICKS (TIMEOUT_TICKS / 2)
  ) u_key_edge (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_evt    (key_evt),
    .key_code_q (key_code_q),
    .long_hold  (long_hold)
  );

  // Candidate images: the latched character written at the cursor, and the
  // last filled position blanked; position 0 is the most significant nibble.
  always_comb begin
    plate_add = plate_disp;
    plate_del = plate_disp;
    for (int i = 0; i < N_CHARS; i++) begin
      if (int'(char_count) == i) begin
        plate_add[PW-4-4*i +: 4] = key_code_q;
      end
      if (int'(char_count) == i + 1) begin
        plate_del[PW-4-4*i +: 4] = BLANK_CODE;
      end
    end
  end

  // Saturating idle count, long backspace detection and commit qualification.
  always_comb begin
    idle_next  = (idle_cnt == IDLE_SAT) ? idle_cnt : idle_cnt + IW'(1);
    bksp_clear = long_hold && (key_code_q == KEY_BKSP);
    can_commit = (char_count == FULL) && (plate_disp != '0);
  end

  // Entry FSM with registered outputs; aborts and inactivity clear the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      plate_disp  <= BLANK_PLATE;
      plate_out   <= '0;
      plate_valid <= 1'b0;
      char_count  <= 3'd0;
      timeout     <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          plate_disp  <= BLANK_PLATE;
          plate_out   <= '0;
          plate_valid <= 1'b0;
          char_count  <= 3'd0;
          idle_cnt    <= '0;
          if (enable) begin
            state <= ENTRY;
          end
        end

        ENTRY: begin
          if (!enable) begin
            state      <= IDLE;
            plate_disp <= BLANK_PLATE;
            char_count <= 3'd0;
            idle_cnt   <= '0;
          end else if (key_evt) begin
            idle_cnt <= '0;
            if (is_char(key_code_q)) begin
              if (char_count < FULL) begin
                plate_disp <= plate_add;
                char_count <= char_count + 3'd1;
              end
            end else if (key_code_q == KEY_BKSP) begin
              if (char_count != 3'd0) begin
                plate_disp <= plate_del;
                char_count <= char_count - 3'd1;
              end
            end else if (key_code_q == KEY_ENTER) begin
              if (can_commit) begin
                plate_out   <= plate_disp;
                plate_valid <= 1'b1;
                state       <= DONE;
              end
            end
          end else if (bksp_clear) begin
            plate_disp <= BLANK_PLATE;
            char_count <= 3'd0;
            idle_cnt   <= idle_next;
          end else if (idle_cnt == IDLE_LAST) begin
            plate_disp <= BLANK_PLATE;
            char_count <= 3'd0;
            timeout    <= 1'b1;
            idle_cnt   <= idle_next;
          end else begin
            idle_cnt <= idle_next;
          end
        end

        DONE: begin
          if (!enable) begin
            state       <= IDLE;
            plate_disp  <= BLANK_PLATE;
            plate_out   <= '0;
            plate_valid <= 1'b0;
            char_count  <= 3'd0;
            idle_cnt    <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plate_entry.sv
// Directed self-checking bench for plate_entry: commit, backspace, overflow,
// zero plate, long hold clear, inactivity timeout, reset and abort.
module tb_plate_entry;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] plate_disp;
  logic [23:0] plate_out;
  logic        plate_valid;
  logic [2:0]  char_count;
  logic        timeout;

  int n_vectors = 0;
  int n_fail    = 0;

  plate_entry dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .plate_disp  (plate_disp),
    .plate_out   (plate_out),
    .plate_valid (plate_valid),
    .char_count  (char_count),
    .timeout     (timeout)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard bound on run time in case the sequence stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Press a key for 'hold' cycles, release it and let the result settle.
  task automatic applyStimulus(input logic [3:0] code, input int hold);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    n_vectors++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic setEnable(input logic level);
    @(negedge clk);
    enable = level;
    @(negedge clk);
  endtask

  initial begin
    int first_pulse;
    int pulses;
    logic saw_to;

    reset     = 1'b1;
    enable    = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(negedge clk);

    checkOutput("rst_disp",  plate_disp, 24'hFFFFFF);
    checkOutput("rst_out",   plate_out, 24'h0);
    checkOutput("rst_valid", 24'(plate_valid), 24'h0);
    checkOutput("rst_count", 24'(char_count), 24'h0);
    checkOutput("rst_to",    24'(timeout), 24'h0);
    reset = 1'b0;

    // Full plate and commit
    setEnable(1'b1);
    for (int k = 1; k <= 6; k++) applyStimulus(4'(k), 3);
    checkOutput("t1_disp",  plate_disp, 24'h123456);
    checkOutput("t1_count", 24'(char_count), 24'h6);
    applyStimulus(4'hF, 3);
    checkOutput("t1_out",   plate_out, 24'h123456);
    checkOutput("t1_valid", 24'(plate_valid), 24'h1);
    checkOutput("t1_dispd", plate_disp, 24'h123456);
    applyStimulus(4'h5, 3);
    checkOutput("t1_done_out",   plate_out, 24'h123456);
    checkOutput("t1_done_count", 24'(char_count), 24'h6);
    setEnable(1'b0);
    checkOutput("t1_idle_out",   plate_out, 24'h0);
    checkOutput("t1_idle_valid", 24'(plate_valid), 24'h0);
    checkOutput("t1_idle_disp",  plate_disp, 24'hFFFFFF);
    checkOutput("t1_idle_count", 24'(char_count), 24'h0);

    // Backspace in the middle of an entry
    setEnable(1'b1);
    applyStimulus(4'hA, 3);
    applyStimulus(4'hB, 3);
    applyStimulus(4'hC, 3);
    checkOutput("t2_abc", plate_disp, 24'hABCFFF);
    applyStimulus(4'hE, 3);
    checkOutput("t2_bksp_disp",  plate_disp, 24'hABFFFF);
    checkOutput("t2_bksp_count", 24'(char_count), 24'h2);
    applyStimulus(4'h7, 3);
    applyStimulus(4'h1, 3);
    applyStimulus(4'h2, 3);
    applyStimulus(4'h3, 3);
    applyStimulus(4'hF, 3);
    checkOutput("t2_out",   plate_out, 24'hAB7123);
    checkOutput("t2_valid", 24'(plate_valid), 24'h1);
    setEnable(1'b0);

    // Seventh character is ignored
    setEnable(1'b1);
    for (int k = 1; k <= 7; k++) applyStimulus(4'(k), 3);
    checkOutput("t3_disp",  plate_disp, 24'h123456);
    checkOutput("t3_count", 24'(char_count), 24'h6);
    applyStimulus(4'hF, 3);
    checkOutput("t3_out", plate_out, 24'h123456);
    setEnable(1'b0);

    // Five characters: ENTER does not commit
    setEnable(1'b1);
    for (int k = 1; k <= 5; k++) applyStimulus(4'(k), 3);
    applyStimulus(4'hF, 3);
    checkOutput("t4_valid", 24'(plate_valid), 24'h0);
    checkOutput("t4_out",   plate_out, 24'h0);
    checkOutput("t4_count", 24'(char_count), 24'h5);
    checkOutput("t4_disp",  plate_disp, 24'h12345F);

    // Long backspace hold clears everything
    applyStimulus(4'hE, 20);
    checkOutput("t5_clear_count", 24'(char_count), 24'h0);
    checkOutput("t5_clear_disp",  plate_disp, 24'hFFFFFF);

    // Held key yields one event; all-zero plate is not committed
    applyStimulus(4'h0, 10);
    checkOutput("t6_hold_count", 24'(char_count), 24'h1);
    checkOutput("t6_hold_disp",  plate_disp, 24'h0FFFFF);
    for (int k = 0; k < 5; k++) applyStimulus(4'h0, 3);
    checkOutput("t6_zero_disp", plate_disp, 24'h000000);
    applyStimulus(4'hF, 3);
    checkOutput("t6_zero_valid", 24'(plate_valid), 24'h0);
    checkOutput("t6_zero_count", 24'(char_count), 24'h6);
    setEnable(1'b0);

    // Inactivity timeout after three keys
    setEnable(1'b1);
    applyStimulus(4'h3, 3);
    applyStimulus(4'h4, 3);
    applyStimulus(4'h5, 3);
    checkOutput("t7_disp", plate_disp, 24'h345FFF);
    first_pulse = -1;
    pulses      = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
      end
    end
    checkOutput("t7_pulses", 24'(pulses), 24'd1);
    checkOutput("t7_when",   24'(first_pulse), 24'd27);
    checkOutput("t7_disp_after",  plate_disp, 24'hFFFFFF);
    checkOutput("t7_count_after", 24'(char_count), 24'h0);

    // Reset mid-entry
    for (int k = 1; k <= 4; k++) applyStimulus(4'(k), 3);
    checkOutput("t8_disp", plate_disp, 24'h1234FF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t8_rst_disp",  plate_disp, 24'hFFFFFF);
    checkOutput("t8_rst_count", 24'(char_count), 24'h0);
    checkOutput("t8_rst_valid", 24'(plate_valid), 24'h0);
    @(negedge clk);
    reset = 1'b0;

    // Enable drop mid-entry aborts silently
    applyStimulus(4'h5, 3);
    applyStimulus(4'h6, 3);
    checkOutput("t9_disp", plate_disp, 24'h56FFFF);
    @(negedge clk);
    enable = 1'b0;
    saw_to = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw_to = saw_to | timeout;
    end
    checkOutput("t9_no_to", 24'(saw_to), 24'h0);
    checkOutput("t9_disp_after",  plate_disp, 24'hFFFFFF);
    checkOutput("t9_count_after", 24'(char_count), 24'h0);
    checkOutput("t9_valid_after", 24'(plate_valid), 24'h0);
    checkOutput("t9_out_after",   plate_out, 24'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_fail);
    $finish;
  end

endmodule

// File: doc/plate_entry.md
Name: plate_entry

Overview:
- Keypad-to-plate front end. It sits between the keypad scanner and the main parking FSM.
- Collects up to 6 plate characters from scanned key codes and supports backspace and clear.
- Presents a live, cursor-style image for the LCD. On ENTER it commits a 24-bit plate, which the parking FSM consumes as "plate != 0".
- Abandoned entries are discarded by an inactivity timeout.

Parameters:
- N_CHARS, 6, number of plate characters (4-bit nibble each); plate width = 4*N_CHARS.
- TIMEOUT_TICKS, 30, clk cycles of inactivity in ENTRY before the entry is discarded.
- BLANK_CODE, 4'hF, nibble shown in unfilled display positions; the LCD renders it as '_'.

Ports:
- clk  input  1  system clock; the same divided clock that drives the parking FSM.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  level from the FSM while in its PLACA state; entry runs only while high.
- key_valid  input  1  level, high while a key is held (from the scanner).
- key_code  input  4  scanner code, sampled with key_valid. Codes 0x0-0xD are characters, 0xE is backspace/clear, 0xF is enter.
- plate_disp  output  24  live entry image, MS nibble = first character.
- plate_out  output  24  committed plate; 0 when nothing is committed.
- plate_valid  output  1  high while plate_out holds a committed plate.
- char_count  output  3  characters currently entered, range 0..N_CHARS.
- timeout  output  1  one-cycle pulse when an entry is discarded by inactivity.

Behaviour:
- Reset (async): state=IDLE, plate_disp=all BLANK_CODE, plate_out=0, plate_valid=0, char_count=0, timeout=0, idle counter=0, key edge register=0.
- Key event: rising edge of key_valid, registered internally.
  - Held keys produce exactly one event.
  - key_code is sampled in the same cycle as the edge.
  - Event-to-output latency is 1 cycle.
- States:
  - IDLE: plate_disp blank. Go to ENTRY on enable=1. Key events are ignored.
  - ENTRY: processes key events (rules below). The idle counter increments every cycle without an event and clears on any event.
  - DONE: plate_out and plate_valid are held. plate_disp shows the committed plate. Key events are ignored. Return to IDLE when enable falls; on that transition clear plate_out, plate_valid, char_count and plate_disp.
- ENTRY rules:
  - Character (0x0-0xD) with char_count<N_CHARS: write the nibble at position char_count, counting from the MS end; increment char_count.
  - Character with char_count==N_CHARS: ignored; no wrap, no shift.
  - 0xE tapped: backspace. If char_count>0, decrement char_count and set that position to BLANK_CODE. If char_count==0, no effect.
  - 0xE held for at least TIMEOUT_TICKS/2 cycles: clears all positions and sets char_count=0. This fires once per hold.
  - 0xF with char_count==N_CHARS and an assembled value !=0: plate_out <= assembled value, plate_valid <= 1, go to DONE.
  - 0xF with char_count<N_CHARS, or with an all-zero plate: ignored and stays in ENTRY, because 0 is the FSM's "no plate" value.
  - Idle counter reaches TIMEOUT_TICKS-1: clear the entry, pulse timeout for 1 cycle, remain in ENTRY while enable=1.
- enable falls in ENTRY: abort to IDLE and clear everything. No commit, no timeout pulse.
- Key edge in the same cycle enable falls: the abort wins and the key is dropped.
- Simultaneous key event and timeout expiry: the key event wins and the counter clears.
- enable high at reset release: go to ENTRY on the first clk edge.
- Reset asserted mid-entry or in DONE: return to reset values immediately; no commit survives.
- Width: idle counter is $clog2(TIMEOUT_TICKS+1) bits and saturates. char_count never exceeds N_CHARS.

Decomposition:
- Shared package holds:
  - key code constants: KEY_BKSP=4'hE, KEY_ENTER=4'hF, KEY_CHAR_MAX=4'hD;
  - BLANK_CODE;
  - state encoding: IDLE, ENTRY, DONE as a 2-bit typedef.
- One sub-module, key_edge: a registered rising-edge detector plus a hold-duration counter. It outputs key_evt, key_code_q and long_hold.
- All remaining logic (FSM, plate register, idle counter) lives in plate_entry.

Test Plan:
- enable=1, keys 1,2,3,4,5,6 then 0xF -> plate_out=24'h123456, plate_valid=1, char_count=6, DONE; enable=0 -> plate_out=0, IDLE.
- Keys A,B,C, 0xE tap, then 7,1,2,3,0xF -> plate_out=24'hAB7123; after the backspace, plate_disp=24'hABFFFF.
- Seven characters 1..7 then 0xF -> 7th ignored, plate_out=24'h123456. Five characters then 0xF -> no commit, still ENTRY.
- Key 0 held for 10 cycles -> one event only (char_count=1). Entry 000000 then 0xF -> no commit.
- Three keys then TIMEOUT_TICKS idle cycles -> timeout pulse for exactly 1 cycle, plate_disp=24'hFFFFFF, char_count=0.
- Reset pulse mid-entry after 4 keys, and enable drop mid-entry -> all outputs at reset values, plate_valid stays 0, no timeout pulse.
